qid_fb_issue_ctrl: RTL

- Issue controller between the QID instruction buffer and the downstream QID pipeline.
- Pops opcodes from the buffer and holds logical-measurement-feedback (LQM_FB) instructions until a measurement-feedback result arrives.
- Resolves each LQM_FB into LQM_X, LQM_Z or unresolved LQM_FB, and delivers it through a registered valid/ready output stage.
- Buffers one early feedback result, so feedback may arrive before, with or after its instruction.

---
 rtl/qid_fb_issue_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/qid_fb_issue_ctrl.sv
// ---------------------------------------------------------------------------
// qid_fb_issue_ctrl
//
// Issue controller between the QID instruction buffer and the QID pipeline.
// Pops opcodes from the buffer head and delivers them through a registered
// valid/ready output stage. Logical-measurement-feedback (LQM_FB) opcodes are
// held until a feedback result is available. They are then resolved into
// LQM_X / LQM_Z, or left as an unresolved LQM_FB. One early feedback result
// is buffered, so feedback may arrive before, with or after its instruction.
//
// Optional feature macro: QID_FB_TIMEOUT_EN
//   Defined   : an LQM_FB that has waited TIMEOUT_CYC cycles is issued
//               unresolved, and the sticky fb_timeout flag is set.
//   Undefined : WAIT_FB waits indefinitely; fb_timeout is tied to 0.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   instbuf_empty        buffer has no entry
//   instbuf_head_opcode  opcode at the buffer head (valid when !instbuf_empty)
//   instbuf_pop          combinational pop of the buffer head
//   measfb_valid/ready   feedback handshake; ready = no feedback pending
//   measfb_xorz          feedback Pauli basis
//   out_valid/ready      output handshake
//   out_opcode           issued opcode
//   out_a_taken          issued LQM_FB was resolved to X or Z
//   stall                high while waiting for feedback
//   wait_cycles          cycles spent in the current or most recent wait
//   issue_cnt            opcodes loaded into the output register (wraps)
//   fb_timeout           sticky feedback-timeout flag
// ---------------------------------------------------------------------------
`ifndef OPCODE_BW
`define OPCODE_BW 8
`endif
`ifndef INVALID_OPCODE
`define INVALID_OPCODE 8'hFF
`endif
`ifndef LQM_FB_OPCODE
`define LQM_FB_OPCODE 8'h20
`endif
`ifndef LQM_X_OPCODE
`define LQM_X_OPCODE 8'h21
`endif
`ifndef LQM_Z_OPCODE
`define LQM_Z_OPCODE 8'h22
`endif
`ifndef PP_X
`define PP_X 2'd1
`endif
`ifndef PP_Z
`define PP_Z 2'd2
`endif

module qid_fb_issue_ctrl #(
  parameter int WAIT_CNT_BW = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instbuf_empty,
  input  logic [`OPCODE_BW-1:0]  instbuf_head_opcode,
  output logic                   instbuf_pop,
  input  logic                   measfb_valid,
  input  logic [1:0]             measfb_xorz,
  output logic                   measfb_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [`OPCODE_BW-1:0]  out_opcode,
  output logic                   out_a_taken,
  output logic                   stall,
  output logic [WAIT_CNT_BW-1:0] wait_cycles,
  output logic [WAIT_CNT_BW-1:0] issue_cnt,
  output logic                   fb_timeout
);

  typedef enum logic {IDLE, WAIT_FB} state_t;

  state_t                  state, state_nxt;
  logic                    fb_pend_valid;
  logic [1:0]              fb_pend_xorz;

  logic                    slot_free, fb_accept, fb_avail, head_is_fb;
  logic [1:0]              fb_sel_xorz;
  logic [`OPCODE_BW-1:0]   res_opcode, load_opcode;
  logic                    res_a_taken, load_a_taken;
  logic                    load, consume, wait_clear, timeout_hit, timeout_fire;
  logic                    timeout_en;

  assign measfb_ready = !fb_pend_valid;
  assign slot_free    = !out_valid || out_ready;
  assign fb_accept    = measfb_valid && measfb_ready;
  assign fb_avail     = fb_pend_valid || fb_accept;
  // Pending feedback is older than anything on the input, so it wins.
  assign fb_sel_xorz  = fb_pend_valid ? fb_pend_xorz : measfb_xorz;
  assign head_is_fb   = !instbuf_empty && (instbuf_head_opcode == `LQM_FB_OPCODE);
  assign stall        = (state == WAIT_FB);

`ifdef QID_FB_TIMEOUT_EN
  assign timeout_en = 1'b1;
`else
  assign timeout_en = 1'b0;
`endif
  assign timeout_hit = timeout_en &&
                       (wait_cycles >= WAIT_CNT_BW'(TIMEOUT_CYC - 1));

  always_comb begin
    res_opcode  = `LQM_FB_OPCODE;
    res_a_taken = 1'b0;
    if (fb_sel_xorz == `PP_X) begin
      res_opcode  = `LQM_X_OPCODE;
      res_a_taken = 1'b1;
    end else if (fb_sel_xorz == `PP_Z) begin
      res_opcode  = `LQM_Z_OPCODE;
      res_a_taken = 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    instbuf_pop  = 1'b0;
    load         = 1'b0;
    load_opcode  = instbuf_head_opcode;
    load_a_taken = 1'b0;
    consume      = 1'b0;
    wait_clear   = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (!instbuf_empty) begin
          if (!head_is_fb) begin
            if (slot_free) begin
              load        = 1'b1;
              instbuf_pop = 1'b1;
            end
          end else if (slot_free && fb_avail) begin
            load         = 1'b1;
            instbuf_pop  = 1'b1;
            consume      = 1'b1;
            load_opcode  = res_opcode;
            load_a_taken = res_a_taken;
          end else begin
            state_nxt  = WAIT_FB;
            wait_clear = 1'b1;
          end
        end
      end
      WAIT_FB: begin
        // A buffer flush removes the waiting LQM_FB; pending feedback stays.
        if (instbuf_empty) begin
          state_nxt = IDLE;
        end else if (slot_free && fb_avail) begin
          load         = 1'b1;
          instbuf_pop  = 1'b1;
          consume      = 1'b1;
          load_opcode  = res_opcode;
          load_a_taken = res_a_taken;
          state_nxt    = IDLE;
        end else if (slot_free && timeout_hit) begin
          load         = 1'b1;
          instbuf_pop  = 1'b1;
          load_opcode  = `LQM_FB_OPCODE;
          timeout_fire = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      fb_pend_valid <= 1'b0;
      fb_pend_xorz  <= 2'b00;
      out_valid     <= 1'b0;
      out_opcode    <= `INVALID_OPCODE;
      out_a_taken   <= 1'b0;
      wait_cycles   <= '0;
      issue_cnt     <= '0;
    end else begin
      state <= state_nxt;

      // A direct consume leaves the pending register empty as well.
      if (consume) begin
        fb_pend_valid <= 1'b0;
      end else if (fb_accept) begin
        fb_pend_valid <= 1'b1;
        fb_pend_xorz  <= measfb_xorz;
      end

      if (load) begin
        out_valid   <= 1'b1;
        out_opcode  <= load_opcode;
        out_a_taken <= load_a_taken;
        issue_cnt   <= issue_cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (wait_clear) begin
        wait_cycles <= '0;
      end else if ((state == WAIT_FB) && (wait_cycles != '1)) begin
        wait_cycles <= wait_cycles + 1'b1;
      end
    end
  end

`ifdef QID_FB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_timeout <= 1'b0;
    end else if (timeout_fire) begin
      fb_timeout <= 1'b1;
    end
  end
`else
  assign fb_timeout = 1'b0;
`endif

endmodule
